// File: rtl/pad_ctrl_bank.sv
// pad_ctrl_bank: per-pad config register bank with synchronized pad inputs; edge interrupts enabled by PAD_CTRL_EDGE_IRQ_EN
module pad_ctrl_bank #(
    parameter int NUM_BIDIR = 54
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [7:0]           req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    input  logic [NUM_BIDIR-1:0] bidir_in,
    output logic [NUM_BIDIR-1:0] bidir_out,
    output logic [NUM_BIDIR-1:0] bidir_oe,
    output logic [NUM_BIDIR-1:0] bidir_cs,
    output logic [NUM_BIDIR-1:0] bidir_sl,
    output logic [NUM_BIDIR-1:0] bidir_ie,
    output logic [NUM_BIDIR-1:0] bidir_pu,
    output logic [NUM_BIDIR-1:0] bidir_pd,
    output logic                 irq
);
    logic                 acc;
    logic [NUM_BIDIR-1:0] sel;
    logic [NUM_BIDIR-1:0] wr_sel;
    logic [NUM_BIDIR-1:0] sync1;
    logic [NUM_BIDIR-1:0] sync2;
    logic [NUM_BIDIR-1:0] rise_en;
    logic [NUM_BIDIR-1:0] fall_en;
    logic [NUM_BIDIR-1:0] pend;
    logic [31:0]          rd_word;
    logic                 unused_wdata;

    assign acc          = req_valid && req_ready;
    assign wr_sel       = {NUM_BIDIR{acc && req_we}} & sel;
    assign unused_wdata = ^req_wdata[31:7];

    // one-hot pad decode; addresses beyond the last pad select nothing
    always_comb begin
        for (int i = 0; i < NUM_BIDIR; i++) sel[i] = (req_addr == 8'(i));
    end

    // config word of the addressed pad, zero for unmapped addresses
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_BIDIR; i++)
            if (sel[i])
                rd_word = {20'd0, pend[i], fall_en[i], rise_en[i], sync2[i], 1'b0,
                           bidir_pd[i], bidir_pu[i], bidir_ie[i], bidir_sl[i],
                           bidir_cs[i], bidir_oe[i], bidir_out[i]};
    end

    // two-flop synchronizer on every pad input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bidir_in;
            sync2 <= sync1;
        end
    end

    // pin-control registers, updated by accepted in-range writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bidir_out <= '0;
            bidir_oe  <= '0;
            bidir_cs  <= '0;
            bidir_sl  <= '0;
            bidir_ie  <= '1;
            bidir_pu  <= '0;
            bidir_pd  <= '0;
        end else begin
            for (int i = 0; i < NUM_BIDIR; i++)
                if (wr_sel[i]) begin
                    bidir_out[i] <= req_wdata[0];
                    bidir_oe[i]  <= req_wdata[1];
                    bidir_cs[i]  <= req_wdata[2];
                    bidir_sl[i]  <= req_wdata[3];
                    bidir_ie[i]  <= req_wdata[4];
                    bidir_pu[i]  <= req_wdata[5];
                    bidir_pd[i]  <= req_wdata[6];
                end
        end
    end

    // single-cycle response path; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            req_ready <= 1'b1;
            rsp_valid <= acc;
            rsp_rdata <= (acc && !req_we) ? rd_word : '0;
        end
    end

`ifdef PAD_CTRL_EDGE_IRQ_EN
    logic [NUM_BIDIR-1:0] prev;
    logic [NUM_BIDIR-1:0] hit;

    assign hit = (rise_en & sync2 & ~prev) | (fall_en & ~sync2 & prev);

    // edge enables, previous level, sticky pending (an edge beats a same-cycle clear) and registered irq
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise_en <= '0;
            fall_en <= '0;
            pend    <= '0;
            prev    <= '0;
            irq     <= 1'b0;
        end else begin
            prev <= sync2;
            irq  <= |pend;
            for (int i = 0; i < NUM_BIDIR; i++) begin
                if (wr_sel[i]) begin
                    rise_en[i] <= req_wdata[9];
                    fall_en[i] <= req_wdata[10];
                end
                pend[i] <= hit[i] | (pend[i] & ~(wr_sel[i] & req_wdata[11]));
            end
        end
    end
`else
    assign rise_en = '0;
    assign fall_en = '0;
    assign pend    = '0;
    assign irq     = 1'b0;
`endif
endmodule

// File: tb/tb_pad_ctrl_bank.sv
// tb_pad_ctrl_bank: table-driven register checks plus reset, burst and edge-interrupt sequences for pad_ctrl_bank
module tb_pad_ctrl_bank;
    localparam int N = 54;
`ifdef PAD_CTRL_EDGE_IRQ_EN
    localparam logic [31:0] EM = 32'h600;
`else
    localparam logic [31:0] EM = 32'h000;
`endif

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         req_valid = 0;
    logic         req_ready;
    logic         req_we = 0;
    logic [7:0]   req_addr = 0;
    logic [31:0]  req_wdata = 0;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic [N-1:0] bidir_in = 0;
    logic [N-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
    logic         irq;

    int n_cmp = 0;
    int n_fail = 0;
    logic [6:0] cfg [N];
    vec_t tv [$];

    pad_ctrl_bank #(.NUM_BIDIR(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .bidir_in(bidir_in),
        .bidir_out(bidir_out), .bidir_oe(bidir_oe), .bidir_cs(bidir_cs),
        .bidir_sl(bidir_sl), .bidir_ie(bidir_ie), .bidir_pu(bidir_pu),
        .bidir_pd(bidir_pd), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < N; p++) cfg[p] = 7'h10;
    endtask

    task automatic chk_pins(input string tag);
        logic [N-1:0] a [7];
        logic [N-1:0] e [7];
        a = '{bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd};
        for (int f = 0; f < 7; f++)
            for (int p = 0; p < N; p++) e[f][p] = cfg[p][f];
        for (int f = 0; f < 7; f++) chk($sformatf("%s_pin%0d", tag, f), 64'(a[f]), 64'(e[f]));
    endtask

    // called just after a negedge; returns just after the next negedge with the response sampled
    task automatic xfer(input logic we, input logic [7:0] a, input logic [31:0] d, input string nm,
                        input logic [31:0] exp);
        req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 0;
        chk({nm, "_valid"}, 64'(rsp_valid), 64'd1);
        chk({nm, "_rdata"}, 64'(rsp_rdata), 64'(exp));
        if (we && int'(a) < N) cfg[int'(a)] = d[6:0];
    endtask

    task automatic wait_neg(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    initial begin
        int cnt;
        tv.push_back('{1'b0, 8'd5,   32'h0,        32'h010});
        tv.push_back('{1'b1, 8'd3,   32'h03,       32'h0});
        tv.push_back('{1'b0, 8'd3,   32'h0,        32'h103});
        tv.push_back('{1'b1, 8'd60,  32'h7F,       32'h0});
        tv.push_back('{1'b0, 8'd60,  32'h0,        32'h0});
        tv.push_back('{1'b1, 8'd10,  32'h7F,       32'h0});
        tv.push_back('{1'b0, 8'd10,  32'h0,        32'h07F});
        tv.push_back('{1'b1, 8'd10,  32'hFFFFFE5A, 32'h0});
        tv.push_back('{1'b0, 8'd10,  32'h0,        32'h05A | EM});
        tv.push_back('{1'b0, 8'd53,  32'h0,        32'h010});
        tv.push_back('{1'b1, 8'd54,  32'h7F,       32'h0});
        tv.push_back('{1'b0, 8'd54,  32'h0,        32'h0});
        tv.push_back('{1'b1, 8'd0,   32'h40,       32'h0});
        tv.push_back('{1'b0, 8'd0,   32'h0,        32'h040});
        tv.push_back('{1'b0, 8'd255, 32'h0,        32'h0});

        model_reset();
        bidir_in = N'(8);
        wait_neg(3);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk_pins("rst");
        rst_n = 1;
        wait_neg(4);
        chk("ready_up", 64'(req_ready), 64'd1);

        foreach (tv[k]) begin
            xfer(tv[k].we, tv[k].addr, tv[k].wdata, $sformatf("vec%0d", k), tv[k].exp);
            chk_pins($sformatf("vec%0d", k));
        end
        chk("irq_idle", 64'(irq), 64'd0);

        // back-to-back reads, responses in order
        req_valid = 1; req_we = 0; req_addr = 3;
        @(negedge clk);
        chk("b2b0_valid", 64'(rsp_valid), 64'd1);
        chk("b2b0_rdata", 64'(rsp_rdata), 64'h103);
        req_addr = 5;
        @(negedge clk);
        chk("b2b1_valid", 64'(rsp_valid), 64'd1);
        chk("b2b1_rdata", 64'(rsp_rdata), 64'h010);
        req_addr = 60;
        @(negedge clk);
        req_valid = 0;
        chk("b2b2_valid", 64'(rsp_valid), 64'd1);
        chk("b2b2_rdata", 64'(rsp_rdata), 64'h0);
        @(negedge clk);
        chk("b2b_idle", 64'(rsp_valid), 64'd0);

        // reset pulse in the middle of a four-read burst
        req_valid = 1; req_we = 0; req_addr = 3;
        @(negedge clk);
        req_addr = 5;
        @(negedge clk);
        chk("burst1_valid", 64'(rsp_valid), 64'd1);
        rst_n = 0; req_addr = 10;
        @(negedge clk);
        rst_n = 1; req_addr = 0;
        chk("burst_rst_valid", 64'(rsp_valid), 64'd0);
        chk("burst_rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        req_valid = 0;
        chk("burst_after1", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("burst_after2", 64'(rsp_valid), 64'd0);
        chk("burst_rdata", 64'(rsp_rdata), 64'd0);
        chk("burst_irq", 64'(irq), 64'd0);
        model_reset();
        chk_pins("burst");
        wait_neg(3);
        xfer(0, 8'd3, 0, "post_rst_rd3", 32'h110);

`ifdef PAD_CTRL_EDGE_IRQ_EN
        xfer(1, 8'd7, 32'h200, "en_rise7", 32'h0);
        bidir_in[7] = 1;
        cnt = 0;
        while (!irq && cnt < 6) begin
            @(negedge clk);
            cnt++;
        end
        chk("irq_within4", 64'(irq && cnt <= 4), 64'd1);
        xfer(0, 8'd7, 0, "rd7_pend", 32'hB00);
        xfer(1, 8'd7, 32'hA00, "w1c7", 32'h0);
        @(negedge clk);
        chk("irq_cleared", 64'(irq), 64'd0);

        bidir_in[7] = 0;
        wait_neg(5);
        chk("fall_ignored", 64'(irq), 64'd0);
        bidir_in[7] = 1;
        wait_neg(5);
        chk("rise2_irq", 64'(irq), 64'd1);
        bidir_in[7] = 0;
        wait_neg(5);
        chk("pend_held", 64'(irq), 64'd1);
        bidir_in[7] = 1;
        wait_neg(2);
        req_valid = 1; req_we = 1; req_addr = 7; req_wdata = 32'hA00;
        @(negedge clk);
        req_valid = 0;
        chk("w1c_race_valid", 64'(rsp_valid), 64'd1);
        chk("w1c_race_irq0", 64'(irq), 64'd1);
        @(negedge clk);
        chk("w1c_race_irq1", 64'(irq), 64'd1);
        xfer(0, 8'd7, 0, "w1c_race_rd", 32'hB00);
`else
        xfer(1, 8'd7, 32'hE00, "noedge_wr7", 32'h0);
        bidir_in[7] = 1;
        wait_neg(5);
        chk("noedge_irq", 64'(irq), 64'd0);
        xfer(0, 8'd7, 0, "noedge_rd7", 32'h100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
